chaining_record_table: RTL and testbench
========================================

Name: chaining_record_table

Overview:
- Holds one chaining record per in-flight vector instruction: destination register, instruction index, and a per-element write-progress mask.
- Sits directly upstream of the chaining hazard checker and drives its record inputs (vd valid/bits, instIndex, elementMask, recordValid), one record per entry.
- Records are allocated at instruction issue, updated as lanes write elements back, and freed at retire.
- elementMask bit = 1 means the element is written and safe to read; 0 means pending.

Parameters:
ENTRIES, 4, number of record slots (power of two, 2..8)
MASK_WIDTH, 128, mask bits per record: 8 registers x 16 offsets
INDEX_WIDTH, 3, instruction index width; MSB is the wrap bit

Ports:
clock  input  1  single clock
reset  input  1  synchronous, active-high reset
alloc_valid  input  1  issue requests a record
alloc_ready  output  1  a free slot exists
alloc_vd_valid  input  1  instruction writes a vector register
alloc_vd  input  5  destination base register
alloc_instIndex  input  INDEX_WIDTH  instruction index
write_valid  input  1  element write-back event
write_instIndex  input  INDEX_WIDTH  writing instruction
write_vd  input  5  absolute register written
write_offset  input  4  element offset within register
retire_valid  input  1  instruction completed
retire_instIndex  input  INDEX_WIDTH  completing instruction
record_valid  output  ENTRIES  per-slot recordValid
record_vd_valid  output  ENTRIES  per-slot vd valid
record_vd  output  5*ENTRIES  per-slot vd, slot i at [5i+4:5i]
record_instIndex  output  INDEX_WIDTH*ENTRIES  per-slot index
record_elementMask  output  MASK_WIDTH*ENTRIES  per-slot mask, slot i at [128i+127:128i]
occupancy  output  clog2(ENTRIES)+1  count of valid slots
dup_error  output  1  sticky flag: protocol violation

Behaviour:
- Reset: all record_valid=0, vd_valid=0, vd=0, instIndex=0, masks=0, occupancy=0, dup_error=0. alloc_ready=1 from the first cycle after reset. Reset mid-operation discards all records within one cycle; inputs are ignored during reset.
- alloc_ready = any slot invalid, computed from registered state only. No same-cycle bypass from a retire.
- Allocate fires on alloc_valid & alloc_ready:
  - Target is the lowest-index invalid slot.
  - Next cycle the slot reads valid=1, vd/vd_valid/instIndex as given, and elementMask all zero.
  - If alloc_vd_valid=0, the mask is loaded all-ones.
- Write, for each valid slot with instIndex==write_instIndex and vd_valid=1:
  - rel = (write_vd - vd) mod 32.
  - If rel<8, set bit {rel[2:0], write_offset}. If rel>=8, no effect.
  - Effect is visible next cycle.
  - Bits only ever set; a repeated write is idempotent.
- Write to a slot allocated in the same cycle is dropped. Upstream guarantees at least one cycle between issue and first write-back.
- Retire: the slot with instIndex==retire_instIndex and valid=1 is cleared to the reset value next cycle.
  - Retire wins over a same-cycle write to that slot.
- Allocate and retire in the same cycle are independent.
  - A slot freed by the retire is not reusable until the next cycle.
  - occupancy = old + fire - retire_hit.
- dup_error sets (sticky until reset) on any of:
  - an alloc fire whose instIndex matches a valid slot;
  - a retire matching no valid slot;
  - alloc_valid while full is NOT an error (backpressure only).
- The write path does not use instIndex age ordering; the downstream checker uses the wrap bit.
- Outputs are straight register outputs; no combinational input-to-output path except alloc_ready, which depends on state only.

Test Plan:
- Reset, then alloc vd=8 idx=1 -> next cycle record_valid=0001, record_vd[4:0]=8, record_instIndex[2:0]=1, mask0=0, occupancy=1, alloc_ready=1.
- With slot0 vd=8, write idx=1 vd=9 offset=3 -> mask0 bit 19 set only. Write vd=16 -> no change (rel=8). Write vd=7 -> no change (rel=31).
- Alloc 4 instructions idx 0..3 -> alloc_ready=0, occupancy=4. Fifth alloc_valid held -> no fire, dup_error=0. Retire idx 2 -> next cycle the alloc fires into slot 2.
- Same cycle: write and retire both to idx 1 -> slot cleared, mask=0. Separately, alloc idx 5 plus retire idx 0 on a full table -> alloc not accepted that cycle, occupancy=3.
- Alloc idx 3 while idx 3 valid -> dup_error=1, held. Retire of an unknown idx also sets it. Reset clears it.
- Alloc with alloc_vd_valid=0 -> mask all ones, and writes to that slot are ignored. Assert reset while 3 slots are valid -> all outputs zero next cycle.

Source files
------------

// File: rtl/chaining_record_table_if.sv
// rtl/chaining_record_table_if.sv - issue/write-back/retire bus and per-slot record outputs
interface chaining_record_table_if #(
   parameter int ENTRIES     = 4,
   parameter int MASK_WIDTH  = 128,
   parameter int INDEX_WIDTH = 3
);
   localparam int OCC_W = $clog2(ENTRIES) + 1;

   logic                          alloc_valid;
   logic                          alloc_ready;
   logic                          alloc_vd_valid;
   logic [4:0]                    alloc_vd;
   logic [INDEX_WIDTH-1:0]        alloc_instIndex;
   logic                          write_valid;
   logic [INDEX_WIDTH-1:0]        write_instIndex;
   logic [4:0]                    write_vd;
   logic [3:0]                    write_offset;
   logic                          retire_valid;
   logic [INDEX_WIDTH-1:0]        retire_instIndex;
   logic [ENTRIES-1:0]            record_valid;
   logic [ENTRIES-1:0]            record_vd_valid;
   logic [5*ENTRIES-1:0]          record_vd;
   logic [INDEX_WIDTH*ENTRIES-1:0] record_instIndex;
   logic [MASK_WIDTH*ENTRIES-1:0] record_elementMask;
   logic [OCC_W-1:0]              occupancy;
   logic                          dup_error;

   modport master (
      output alloc_valid, alloc_vd_valid, alloc_vd, alloc_instIndex,
      output write_valid, write_instIndex, write_vd, write_offset,
      output retire_valid, retire_instIndex,
      input  alloc_ready, record_valid, record_vd_valid, record_vd,
      input  record_instIndex, record_elementMask, occupancy, dup_error
   );

   modport slave (
      input  alloc_valid, alloc_vd_valid, alloc_vd, alloc_instIndex,
      input  write_valid, write_instIndex, write_vd, write_offset,
      input  retire_valid, retire_instIndex,
      output alloc_ready, record_valid, record_vd_valid, record_vd,
      output record_instIndex, record_elementMask, occupancy, dup_error
   );
endinterface

// File: rtl/chaining_record_table.sv
// rtl/chaining_record_table.sv - per-instruction chaining records feeding the hazard checker
module chaining_record_table #(
   parameter int ENTRIES     = 4,
   parameter int MASK_WIDTH  = 128,
   parameter int INDEX_WIDTH = 3
) (
   input logic clock,
   input logic reset,
   chaining_record_table_if.slave bus
);
   localparam int SLOT_W = $clog2(ENTRIES);
   localparam int OCC_W  = $clog2(ENTRIES) + 1;

   logic [ENTRIES-1:0]     valid_q;
   logic [ENTRIES-1:0]     vd_valid_q;
   logic [4:0]             vd_q     [ENTRIES];
   logic [INDEX_WIDTH-1:0] idx_q    [ENTRIES];
   logic [MASK_WIDTH-1:0]  mask_q   [ENTRIES];
   logic [OCC_W-1:0]       occ_q;
   logic                   dup_q;

   logic [SLOT_W-1:0]      alloc_slot;
   logic                   fire;
   logic [ENTRIES-1:0]     alloc_match;
   logic [ENTRIES-1:0]     retire_hit;
   logic [ENTRIES-1:0]     alloc_onehot;
   logic [ENTRIES-1:0]     valid_d;
   logic [MASK_WIDTH-1:0]  set_mask [ENTRIES];
   logic [4:0]             rel      [ENTRIES];
   logic [OCC_W-1:0]       occ_d;

   assign bus.alloc_ready = ~&valid_q;
   assign fire            = bus.alloc_valid & bus.alloc_ready;

   // Descending scan so the last hit is the lowest free slot.
   always_comb begin
      alloc_slot = '0;
      for (int i = ENTRIES - 1; i >= 0; i--)
         if (!valid_q[i]) alloc_slot = SLOT_W'(i);
   end

   always_comb begin
      alloc_onehot = '0;
      alloc_match  = '0;
      retire_hit   = '0;
      occ_d        = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         rel[i]         = bus.write_vd - vd_q[i];
         set_mask[i]    = '0;
         alloc_match[i] = valid_q[i] && (idx_q[i] == bus.alloc_instIndex);
         retire_hit[i]  = bus.retire_valid && valid_q[i] && (idx_q[i] == bus.retire_instIndex);
         if (bus.write_valid && valid_q[i] && vd_valid_q[i] &&
             (idx_q[i] == bus.write_instIndex) && (rel[i] < 5'd8))
            set_mask[i][{rel[i][2:0], bus.write_offset}] = 1'b1;
      end
      alloc_onehot[alloc_slot] = fire;
      valid_d = (valid_q & ~retire_hit) | alloc_onehot;
      for (int i = 0; i < ENTRIES; i++)
         occ_d = occ_d + OCC_W'(valid_d[i]);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q    <= '0;
         vd_valid_q <= '0;
         occ_q      <= '0;
         dup_q      <= 1'b0;
         for (int i = 0; i < ENTRIES; i++) begin
            vd_q[i]   <= '0;
            idx_q[i]  <= '0;
            mask_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         occ_q   <= occ_d;
         dup_q   <= dup_q | (fire & |alloc_match) | (bus.retire_valid & ~|retire_hit);
         // Retire beats write-back; alloc only targets free slots so never overlaps either.
         for (int i = 0; i < ENTRIES; i++) begin
            if (retire_hit[i]) begin
               vd_valid_q[i] <= 1'b0;
               vd_q[i]       <= '0;
               idx_q[i]      <= '0;
               mask_q[i]     <= '0;
            end else if (alloc_onehot[i]) begin
               vd_valid_q[i] <= bus.alloc_vd_valid;
               vd_q[i]       <= bus.alloc_vd;
               idx_q[i]      <= bus.alloc_instIndex;
               mask_q[i]     <= bus.alloc_vd_valid ? '0 : '1;
            end else begin
               mask_q[i]     <= mask_q[i] | set_mask[i];
            end
         end
      end
   end

   assign bus.record_valid    = valid_q;
   assign bus.record_vd_valid = vd_valid_q;
   assign bus.occupancy       = occ_q;
   assign bus.dup_error       = dup_q;

   for (genvar g = 0; g < ENTRIES; g++) begin : g_pack
      assign bus.record_vd[5*g +: 5]                            = vd_q[g];
      assign bus.record_instIndex[INDEX_WIDTH*g +: INDEX_WIDTH] = idx_q[g];
      assign bus.record_elementMask[MASK_WIDTH*g +: MASK_WIDTH] = mask_q[g];
   end
endmodule

// File: tb/tb_chaining_record_table.sv
// tb/tb_chaining_record_table.sv - directed and randomized checks against a record-table model
module tb_chaining_record_table;
   logic clock;
   logic reset;
   int   tests_run;
   int   tests_failed;

   chaining_record_table_if #(.ENTRIES(4), .MASK_WIDTH(128), .INDEX_WIDTH(3)) bus ();

   chaining_record_table #(.ENTRIES(4), .MASK_WIDTH(128), .INDEX_WIDTH(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference model: one record per slot, updated once per clock from the current inputs.
   bit         m_valid [4];
   bit         m_vdv   [4];
   logic [4:0] m_vd    [4];
   logic [2:0] m_idx   [4];
   logic [127:0] m_mask [4];
   bit         m_dup;

   function automatic void model_clear();
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 0; m_vdv[i] = 0; m_vd[i] = '0; m_idx[i] = '0; m_mask[i] = '0;
      end
      m_dup = 0;
   endfunction

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < 4; i++) n += m_valid[i];
      return n;
   endfunction

   function automatic void model_step();
      bit         o_valid [4];
      logic [2:0] o_idx   [4];
      int free, rel, b;
      bit hit, fire;
      if (reset) begin
         model_clear();
         return;
      end
      o_valid = m_valid;
      o_idx   = m_idx;
      free = -1;
      for (int i = 0; i < 4; i++) if (!o_valid[i] && free < 0) free = i;
      fire = bus.alloc_valid && (free >= 0);
      for (int i = 0; i < 4; i++) begin
         if (bus.write_valid && o_valid[i] && m_vdv[i] && o_idx[i] == bus.write_instIndex) begin
            rel = (int'(bus.write_vd) - int'(m_vd[i]) + 32) % 32;
            if (rel < 8) begin
               b = rel * 16 + int'(bus.write_offset);
               m_mask[i][b] = 1'b1;
            end
         end
      end
      hit = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.retire_valid && o_valid[i] && o_idx[i] == bus.retire_instIndex) begin
            hit = 1;
            m_valid[i] = 0; m_vdv[i] = 0; m_vd[i] = '0; m_idx[i] = '0; m_mask[i] = '0;
         end
      end
      if (bus.retire_valid && !hit) m_dup = 1;
      if (fire) begin
         for (int i = 0; i < 4; i++)
            if (o_valid[i] && o_idx[i] == bus.alloc_instIndex) m_dup = 1;
         m_valid[free] = 1;
         m_vdv[free]   = bus.alloc_vd_valid;
         m_vd[free]    = bus.alloc_vd;
         m_idx[free]   = bus.alloc_instIndex;
         m_mask[free]  = bus.alloc_vd_valid ? '0 : {128{1'b1}};
      end
   endfunction

   function automatic logic [3:0] exp_valid();
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = m_valid[i];
      return r;
   endfunction

   function automatic logic [3:0] exp_vdv();
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = m_vdv[i];
      return r;
   endfunction

   function automatic logic [19:0] exp_vd();
      logic [19:0] r;
      for (int i = 0; i < 4; i++) r[5*i +: 5] = m_vd[i];
      return r;
   endfunction

   function automatic logic [11:0] exp_idx();
      logic [11:0] r;
      for (int i = 0; i < 4; i++) r[3*i +: 3] = m_idx[i];
      return r;
   endfunction

   function automatic logic [511:0] exp_mask();
      logic [511:0] r;
      for (int i = 0; i < 4; i++) r[128*i +: 128] = m_mask[i];
      return r;
   endfunction

   task automatic idle_inputs();
      bus.alloc_valid = 0; bus.alloc_vd_valid = 0; bus.alloc_vd = '0; bus.alloc_instIndex = '0;
      bus.write_valid = 0; bus.write_instIndex = '0; bus.write_vd = '0; bus.write_offset = '0;
      bus.retire_valid = 0; bus.retire_instIndex = '0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      tick();
      tick();
      reset = 0;
   endtask

   task automatic alloc(input logic [2:0] idx, input logic [4:0] vd, input bit vdv);
      bus.alloc_valid = 1; bus.alloc_instIndex = idx; bus.alloc_vd = vd; bus.alloc_vd_valid = vdv;
      tick();
      bus.alloc_valid = 0;
   endtask

   task automatic write(input logic [2:0] idx, input logic [4:0] vd, input logic [3:0] off);
      bus.write_valid = 1; bus.write_instIndex = idx; bus.write_vd = vd; bus.write_offset = off;
      tick();
      bus.write_valid = 0;
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++;
      if (bus.record_valid !== 4'b0 || bus.occupancy !== 3'd0 || bus.dup_error !== 1'b0 ||
          bus.record_vd !== 20'b0 || bus.record_instIndex !== 12'b0 || bus.record_elementMask !== 512'b0) begin
         tests_failed++;
         $display("FAIL reset_state: valid=%b occ=%0d dup=%b vd=%h idx=%h, required all zero",
                  bus.record_valid, bus.occupancy, bus.dup_error, bus.record_vd, bus.record_instIndex);
      end
      tests_run++;
      if (bus.alloc_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ready: got %b, required 1", bus.alloc_ready);
      end
   endtask

   task automatic test_alloc_write();
      logic [127:0] want;
      do_reset();
      alloc(3'd1, 5'd8, 1);
      tests_run++;
      if (bus.record_valid !== 4'b0001 || bus.record_vd[4:0] !== 5'd8 || bus.record_instIndex[2:0] !== 3'd1 ||
          bus.record_elementMask[127:0] !== 128'b0 || bus.occupancy !== 3'd1 || bus.alloc_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL first_alloc: valid=%b vd=%0d idx=%0d occ=%0d ready=%b, required 0001/8/1/1/1",
                  bus.record_valid, bus.record_vd[4:0], bus.record_instIndex[2:0], bus.occupancy, bus.alloc_ready);
      end
      want = 128'b0;
      want[19] = 1'b1;
      write(3'd1, 5'd9, 4'd3);
      tests_run++;
      if (bus.record_elementMask[127:0] !== want) begin
         tests_failed++;
         $display("FAIL write_rel1: mask=%h, required %h", bus.record_elementMask[127:0], want);
      end
      write(3'd1, 5'd16, 4'd3);
      write(3'd1, 5'd7, 4'd3);
      write(3'd1, 5'd9, 4'd3);
      tests_run++;
      if (bus.record_elementMask[127:0] !== want) begin
         tests_failed++;
         $display("FAIL write_out_of_range: mask=%h, required %h", bus.record_elementMask[127:0], want);
      end
      write(3'd2, 5'd8, 4'd0);
      write(3'd1, 5'd15, 4'd15);
      want[127] = 1'b1;
      tests_run++;
      if (bus.record_elementMask[127:0] !== want || bus.record_elementMask !== exp_mask()) begin
         tests_failed++;
         $display("FAIL write_rel7: mask=%h, required %h", bus.record_elementMask[127:0], want);
      end
   endtask

   task automatic test_full_backpressure();
      do_reset();
      for (int k = 0; k < 4; k++) alloc(3'(k), 5'($urandom_range(0, 31)), 1);
      tests_run++;
      if (bus.alloc_ready !== 1'b0 || bus.occupancy !== 3'd4) begin
         tests_failed++;
         $display("FAIL full: ready=%b occ=%0d, required 0/4", bus.alloc_ready, bus.occupancy);
      end
      bus.alloc_valid = 1; bus.alloc_instIndex = 3'd4; bus.alloc_vd = 5'd20; bus.alloc_vd_valid = 1;
      tick();
      tick();
      tests_run++;
      if (bus.occupancy !== 3'd4 || bus.dup_error !== 1'b0 || bus.record_instIndex !== exp_idx()) begin
         tests_failed++;
         $display("FAIL backpressure: occ=%0d dup=%b idx=%h, required 4/0/%h",
                  bus.occupancy, bus.dup_error, bus.record_instIndex, exp_idx());
      end
      bus.retire_valid = 1; bus.retire_instIndex = 3'd2;
      tick();
      bus.retire_valid = 0;
      tests_run++;
      if (bus.record_valid !== 4'b1011 || bus.occupancy !== 3'd3) begin
         tests_failed++;
         $display("FAIL retire_no_bypass: valid=%b occ=%0d, required 1011/3", bus.record_valid, bus.occupancy);
      end
      tick();
      bus.alloc_valid = 0;
      tests_run++;
      if (bus.record_valid !== 4'b1111 || bus.record_instIndex[8:6] !== 3'd4 || bus.occupancy !== 3'd4) begin
         tests_failed++;
         $display("FAIL refill_slot2: valid=%b idx2=%0d occ=%0d, required 1111/4/4",
                  bus.record_valid, bus.record_instIndex[8:6], bus.occupancy);
      end
   endtask

   task automatic test_write_retire_same();
      do_reset();
      alloc(3'd0, 5'd0, 1);
      alloc(3'd1, 5'd4, 1);
      bus.write_valid = 1; bus.write_instIndex = 3'd1; bus.write_vd = 5'd4; bus.write_offset = 4'd5;
      bus.retire_valid = 1; bus.retire_instIndex = 3'd1;
      tick();
      idle_inputs();
      tests_run++;
      if (bus.record_valid !== 4'b0001 || bus.record_elementMask[255:128] !== 128'b0 || bus.record_instIndex[5:3] !== 3'd0) begin
         tests_failed++;
         $display("FAIL retire_beats_write: valid=%b mask1=%h, required 0001/0",
                  bus.record_valid, bus.record_elementMask[255:128]);
      end
      for (int k = 1; k < 4; k++) alloc(3'(k), 5'(k * 3), 1);
      bus.alloc_valid = 1; bus.alloc_instIndex = 3'd5; bus.alloc_vd = 5'd1; bus.alloc_vd_valid = 1;
      bus.retire_valid = 1; bus.retire_instIndex = 3'd0;
      tick();
      bus.retire_valid = 0;
      tests_run++;
      if (bus.occupancy !== 3'd3 || bus.record_valid !== 4'b1110) begin
         tests_failed++;
         $display("FAIL alloc_retire_full: occ=%0d valid=%b, required 3/1110", bus.occupancy, bus.record_valid);
      end
      tick();
      bus.alloc_valid = 0;
      tests_run++;
      if (bus.occupancy !== 3'd4 || bus.record_instIndex[2:0] !== 3'd5 || bus.dup_error !== 1'b0) begin
         tests_failed++;
         $display("FAIL reuse_slot0: occ=%0d idx0=%0d dup=%b, required 4/5/0",
                  bus.occupancy, bus.record_instIndex[2:0], bus.dup_error);
      end
   endtask

   task automatic test_dup();
      do_reset();
      alloc(3'd3, 5'd2, 1);
      alloc(3'd3, 5'd6, 1);
      tick();
      tick();
      tests_run++;
      if (bus.dup_error !== 1'b1) begin
         tests_failed++;
         $display("FAIL dup_alloc_sticky: got %b, required 1", bus.dup_error);
      end
      do_reset();
      tests_run++;
      if (bus.dup_error !== 1'b0) begin
         tests_failed++;
         $display("FAIL dup_reset: got %b, required 0", bus.dup_error);
      end
      bus.retire_valid = 1; bus.retire_instIndex = 3'd6;
      tick();
      bus.retire_valid = 0;
      tick();
      tests_run++;
      if (bus.dup_error !== 1'b1 || bus.occupancy !== 3'd0) begin
         tests_failed++;
         $display("FAIL dup_retire_unknown: dup=%b occ=%0d, required 1/0", bus.dup_error, bus.occupancy);
      end
   endtask

   task automatic test_vd_invalid_and_reset();
      do_reset();
      alloc(3'd2, 5'd10, 0);
      write(3'd2, 5'd10, 4'd0);
      tests_run++;
      if (bus.record_elementMask[127:0] !== {128{1'b1}} || bus.record_vd_valid !== 4'b0000) begin
         tests_failed++;
         $display("FAIL novd_mask: mask=%h vdv=%b, required all ones/0000",
                  bus.record_elementMask[127:0], bus.record_vd_valid);
      end
      alloc(3'd3, 5'd30, 1);
      alloc(3'd4, 5'd1, 1);
      write(3'd3, 5'd2, 4'd9);
      tests_run++;
      if (bus.record_elementMask !== exp_mask() || bus.record_elementMask[128+4*16+9] !== 1'b1) begin
         tests_failed++;
         $display("FAIL wrap_write: mask1=%h, required %h", bus.record_elementMask[255:128], m_mask[1]);
      end
      reset = 1;
      bus.alloc_valid = 1; bus.alloc_instIndex = 3'd6; bus.alloc_vd_valid = 1;
      tick();
      idle_inputs();
      tests_run++;
      if (bus.record_valid !== 4'b0 || bus.record_vd_valid !== 4'b0 || bus.record_vd !== 20'b0 ||
          bus.record_instIndex !== 12'b0 || bus.record_elementMask !== 512'b0 || bus.occupancy !== 3'd0) begin
         tests_failed++;
         $display("FAIL midrun_reset: valid=%b occ=%0d, required all zero", bus.record_valid, bus.occupancy);
      end
      reset = 0;
   endtask

   task automatic test_random();
      int bad_state, bad_mask, bad_ready;
      int s;
      bad_state = 0; bad_mask = 0; bad_ready = 0;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         idle_inputs();
         reset = ($urandom_range(0, 199) == 0);
         bus.alloc_valid     = ($urandom_range(0, 1) == 1);
         bus.alloc_vd_valid  = ($urandom_range(0, 7) != 0);
         bus.alloc_vd        = 5'($urandom_range(0, 31));
         bus.alloc_instIndex = 3'($urandom_range(0, 7));
         bus.write_valid     = ($urandom_range(0, 3) != 0);
         s = $urandom_range(0, 3);
         bus.write_instIndex = ($urandom_range(0, 4) != 0) ? m_idx[s] : 3'($urandom_range(0, 7));
         bus.write_vd        = m_vd[s] + 5'($urandom_range(0, 9)) - 5'($urandom_range(0, 1));
         bus.write_offset    = 4'($urandom_range(0, 15));
         bus.retire_valid    = ($urandom_range(0, 4) == 0);
         bus.retire_instIndex = ($urandom_range(0, 3) != 0) ? m_idx[$urandom_range(0, 3)] : 3'($urandom_range(0, 7));
         if (!reset && bus.alloc_ready !== (model_count() < 4)) bad_ready++;
         tick();
         if (bus.record_valid !== exp_valid() || bus.record_vd_valid !== exp_vdv() || bus.record_vd !== exp_vd() ||
             bus.record_instIndex !== exp_idx() || bus.occupancy !== 3'(model_count()) || bus.dup_error !== m_dup) begin
            if (bad_state == 0)
               $display("FAIL random_state cycle %0d: valid=%b idx=%h occ=%0d dup=%b, required %b/%h/%0d/%b",
                        c, bus.record_valid, bus.record_instIndex, bus.occupancy, bus.dup_error,
                        exp_valid(), exp_idx(), model_count(), m_dup);
            bad_state++;
         end
         if (bus.record_elementMask !== exp_mask()) begin
            if (bad_mask == 0)
               $display("FAIL random_mask cycle %0d: got %h, required %h", c, bus.record_elementMask[255:0], exp_mask()[255:0]);
            bad_mask++;
         end
      end
      reset = 0;
      idle_inputs();
      tests_run++;
      if (bad_state != 0) tests_failed++;
      tests_run++;
      if (bad_mask != 0) tests_failed++;
      tests_run++;
      if (bad_ready != 0) begin
         tests_failed++;
         $display("FAIL random_ready: %0d cycles disagreed, required 0", bad_ready);
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      reset = 1;
      idle_inputs();
      model_clear();
      test_reset();
      test_alloc_write();
      test_full_backpressure();
      test_write_retire_same();
      test_dup();
      test_vd_invalid_and_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end
endmodule
